// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the display path: segment vector type,
// blank pattern and the hex-to-segment encoding ({a,b,c,d,e,f,g}, active high).
package seg_pkg;

   localparam int SEG_W = 7;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h00;

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t seg;
      case (nib)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h7B;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h4E;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex7_decoder.sv
// Single-nibble 7-segment decoder, shared with the single-digit display path.
module hex7_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   // Pure table lookup, no state.
   always_comb begin
      seg = hex_to_seg(nib);
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit hex display driver. A slot timer steps one digit
// per DIGIT_CYCLES clocks; new frames are staged and only committed at a frame
// boundary (or at any time while scanning is disabled) so a frame never tears.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int DIGIT_CYCLES = 50000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   data_in,
   input  logic [N_DIGITS-1:0]     blank_in,
   output logic [N_DIGITS-1:0]     an,
   output logic                    a,
   output logic                    b,
   output logic                    c,
   output logic                    d,
   output logic                    e,
   output logic                    f,
   output logic                    g,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int DIV_W = $clog2(DIGIT_CYCLES);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [DIV_W-1:0]        div;
   logic [IDX_W-1:0]        idx;
   logic                    enable_q;
   logic [4*N_DIGITS-1:0]   disp_data;
   logic [N_DIGITS-1:0]     disp_blank;
   logic [4*N_DIGITS-1:0]   stg_data;
   logic [N_DIGITS-1:0]     stg_blank;

   logic                    slot_end;
   logic                    wrap;
   logic                    commit;

   logic [3:0]              cur_nib;
   logic                    cur_blank;
   logic [N_DIGITS-1:0]     an_sel;
   logic                    show;
   seg_t                    dec_seg;
   seg_t                    seg_out;

   assign slot_end = (div == DIV_LAST);
   assign wrap     = enable && slot_end && (idx == IDX_LAST);
   // While disabled nothing is visible, so the display may be updated freely.
   assign commit   = !enable || wrap;

   // Slot timer, digit index, frame pulse and registered enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         idx         <= '0;
         frame_start <= 1'b0;
         enable_q    <= 1'b0;
      end else begin
         enable_q <= enable;
         if (!enable) begin
            div         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
         end else begin
            frame_start <= wrap;
            if (slot_end) begin
               div <= '0;
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

   // Double buffer: a load on a commit edge bypasses the stage (newest wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_data  <= '0;
         disp_blank <= '0;
         stg_data   <= '0;
         stg_blank  <= '0;
         pending    <= 1'b0;
      end else if (commit) begin
         if (load) begin
            disp_data  <= data_in;
            disp_blank <= blank_in;
            pending    <= 1'b0;
         end else if (pending) begin
            disp_data  <= stg_data;
            disp_blank <= stg_blank;
            pending    <= 1'b0;
         end
      end else if (load) begin
         stg_data  <= data_in;
         stg_blank <= blank_in;
         pending   <= 1'b1;
      end
   end

   // Select the current digit's nibble, blank flag and anode bit.
   always_comb begin
      cur_nib   = '0;
      cur_blank = 1'b0;
      an_sel    = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_nib   = disp_data[4*k +: 4];
            cur_blank = disp_blank[k];
            an_sel[k] = 1'b1;
         end
      end
   end

   hex7_decoder u_dec (
      .nib (cur_nib),
      .seg (dec_seg)
   );

   assign show    = enable_q && !cur_blank;
   assign an      = show ? an_sel : '0;
   assign seg_out = show ? dec_seg : SEG_BLANK;
   assign {a, b, c, d, e, f, g} = seg_out;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (N_DIGITS=4, DIGIT_CYCLES=4).
// The driver applies inputs, advances a frame-position reference model and
// queues the expected post-edge outputs; a monitor compares on the falling edge.
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int FRAME = N * DC;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          load;
   logic [15:0]   data_in;
   logic [3:0]    blank_in;
   logic [3:0]    an;
   logic          a, b, c, d, e, f, g;
   logic          pending;
   logic          frame_start;

   always #5 clk = ~clk;

   seg_scan_driver #(.N_DIGITS(N), .DIGIT_CYCLES(DC)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .load        (load),
      .data_in     (data_in),
      .blank_in    (blank_in),
      .an          (an),
      .a           (a),
      .b           (b),
      .c           (c),
      .d           (d),
      .e           (e),
      .f           (f),
      .g           (g),
      .pending     (pending),
      .frame_start (frame_start)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       pend;
      logic       fs;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   // Reference model: run = cycles spent scanning since the last disable/reset,
   // so the frame position is run % FRAME and the digit is (run / DC) % N.
   int         run;
   logic       en_q_m;
   logic [3:0] disp_n [N];
   logic       disp_b [N];
   logic [3:0] stg_n  [N];
   logic       stg_b  [N];
   logic       pend_m;
   logic       fs_m;

   logic          cur_en;
   logic [15:0]   cur_d;
   logic [3:0]    cur_b;

   task automatic model_edge(input logic r, input logic en, input logic ld,
                             input logic [15:0] din, input logic [3:0] bin);
      logic wrap_now;
      if (r) begin
         run = 0; en_q_m = 1'b0; pend_m = 1'b0; fs_m = 1'b0;
         for (int k = 0; k < N; k++) begin
            disp_n[k] = 4'h0; disp_b[k] = 1'b0; stg_n[k] = 4'h0; stg_b[k] = 1'b0;
         end
      end else begin
         wrap_now = en && ((run % FRAME) == FRAME - 1);
         if (!en || wrap_now) begin
            if (ld) begin
               for (int k = 0; k < N; k++) begin
                  disp_n[k] = din[4*k +: 4]; disp_b[k] = bin[k];
               end
               pend_m = 1'b0;
            end else if (pend_m) begin
               for (int k = 0; k < N; k++) begin
                  disp_n[k] = stg_n[k]; disp_b[k] = stg_b[k];
               end
               pend_m = 1'b0;
            end
         end else if (ld) begin
            for (int k = 0; k < N; k++) begin
               stg_n[k] = din[4*k +: 4]; stg_b[k] = bin[k];
            end
            pend_m = 1'b1;
         end
         fs_m   = wrap_now;
         run    = en ? run + 1 : 0;
         en_q_m = en;
      end
   endtask

   function automatic exp_t model_out();
      exp_t x;
      int   dig;
      dig   = (run / DC) % N;
      x.an  = 4'b0000;
      x.seg = 7'h00;
      if (en_q_m && !disp_b[dig]) begin
         x.an  = 4'(1 << dig);
         x.seg = seg_tab[disp_n[dig]];
      end
      x.pend = pend_m;
      x.fs   = fs_m;
      return x;
   endfunction

   task automatic step(input logic r, input logic en, input logic ld,
                       input logic [15:0] din, input logic [3:0] bin);
      rst = r; enable = en; load = ld; data_in = din; blank_in = bin;
      model_edge(r, en, ld, din, bin);
      @(posedge clk);
      exp_q.push_back(model_out());
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, cur_en, 1'b0, cur_d, cur_b);
   endtask

   task automatic go_to_pos(input int pos);
      for (int i = 0; i < FRAME && (run % FRAME) != pos; i++) idle(1);
   endtask

   task automatic do_load(input logic [15:0] din, input logic [3:0] bin);
      cur_d = din; cur_b = bin;
      step(1'b0, cur_en, 1'b1, din, bin);
   endtask

   // Monitor: compare every presented output cycle against the scoreboard.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         total++;
         if (an !== x.an) begin
            bad++; $display("FAIL an cyc=%0d got=%b exp=%b", cyc, an, x.an);
         end
         total++;
         if ({a, b, c, d, e, f, g} !== x.seg) begin
            bad++; $display("FAIL seg cyc=%0d got=%h exp=%h", cyc, {a, b, c, d, e, f, g}, x.seg);
         end
         total++;
         if (pending !== x.pend) begin
            bad++; $display("FAIL pending cyc=%0d got=%b exp=%b", cyc, pending, x.pend);
         end
         total++;
         if (frame_start !== x.fs) begin
            bad++; $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, x.fs);
         end
      end
   end

   initial begin
      rst = 1'b1; enable = 1'b1; load = 1'b0; data_in = '0; blank_in = '0;
      cur_en = 1'b1; cur_d = '0; cur_b = '0;
      @(posedge clk); #1;

      // Reset held 3 cycles, then idle scan of zeros.
      repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      idle(40);

      // Basic load mid-frame.
      go_to_pos(5);
      do_load(16'h12AF, 4'h0);
      idle(36);

      // Two loads in one frame: only the second is shown.
      go_to_pos(2);
      do_load(16'h1111, 4'h0);
      idle(3);
      do_load(16'h2222, 4'h0);
      idle(30);

      // Load on the wrap edge itself commits directly.
      go_to_pos(FRAME - 1);
      do_load(16'h5A3C, 4'h0);
      idle(20);

      // Blanking.
      go_to_pos(7);
      do_load(16'h8888, 4'b1010);
      idle(40);

      // Enable drop in slot 2, load while disabled, re-enable.
      go_to_pos(9);
      cur_en = 1'b0;
      idle(3);
      do_load(16'hBEEF, 4'h0);
      idle(3);
      cur_en = 1'b1;
      idle(40);

      // Reset in slot 3 with pending data.
      go_to_pos(12);
      do_load(16'h7654, 4'h0);
      idle(1);
      step(1'b1, 1'b1, 1'b0, cur_d, cur_b);
      cur_d = '0; cur_b = '0;
      idle(20);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r, ld;
         logic [15:0] dr;
         logic [3:0] br;
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 7) == 0);
         dr = 16'($urandom);
         br = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
         if (ld) begin
            cur_d = dr; cur_b = br;
         end
         step(r, cur_en, ld, cur_d, cur_b);
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain got=%0d exp=0 entries left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
